gpioemu_mul_core: RTL
=====================

// Module: gpioemu_mul_core
// PURPOSE
//  Iterative shift-and-add multiplier. Sits directly downstream of the gpioemu bus register file:
//  takes A (arg1 register, 0x037F) and B (arg2 register, 0x0388), starts on a write to the status
//  register (0x03A0), and returns the product (read at 0x0390) and status flags (read at 0x03A0).
//  It handles one operation at a time and terminates early, so latency depends on B.
// PARAMETERS
//  WIDTH    32   operand width; result register width; product computed internally on 2*WIDTH bits
//  CNT_W    6    width of the iteration counter; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous reset, active-high
//  start      in   1      1-cycle request; operands sampled on the same edge
//  arg_a      in   WIDTH  multiplicand
//  arg_b      in   WIDTH  multiplier
//  busy       out  1      1 while state==RUN
//  done       out  1      level; 1 while state==DONE
//  overflow   out  1      1 when product bits [2*WIDTH-1:WIDTH] != 0; valid while done==1
//  result     out  WIDTH  product bits [WIDTH-1:0]; holds the last completed value
//  ones       out  CNT_W  popcount of result; registered and valid while done==1
// BEHAVIOUR
//  Reset: all outputs are 0 (busy, done, overflow, result, ones), state=IDLE, internal registers 0.
//  States: IDLE -> RUN -> DONE. DONE behaves like IDLE for start; there is no path back to IDLE except reset.
//  IDLE/DONE, start=1: mcand <= {WIDTH'0, arg_a}, mplier <= arg_b, acc <= 0, cnt <= 0, done <= 0,
//    state <= RUN. result, overflow and ones keep their old values until the new operation completes.
//  RUN, every cycle: if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, no carry out of the top bit);
//    mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
//  RUN exits to DONE when (mplier >> 1) == 0 or cnt == WIDTH-1. On that exit edge:
//    result <= final acc[WIDTH-1:0], overflow <= |final acc[2*WIDTH-1:WIDTH], ones <= popcount(final acc[WIDTH-1:0]).
//    "Final acc" includes this cycle's addition.
//  Latency: the number of RUN cycles is msb_index(arg_b)+1, with a minimum of 1 (arg_b==0 gives 1 cycle).
//    busy rises 1 cycle after the start edge; done rises on the edge after the last RUN cycle.
//    Example: B=8 gives busy for 4 cycles and done at start+5 edges.
//  start while busy: ignored. Operands are not resampled and the operation is not restarted.
//  start and reset in the same cycle: reset wins.
//  Reset mid-RUN: aborts the operation; all outputs return to 0 on the next edge.
//  arg_a==0 or arg_b==0: result=0, overflow=0, ones=0.
//  Unsigned arithmetic only; there is no saturation. overflow only flags truncation.
// STRUCTURE
//  Shared package gpioemu_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//    - register address constants ADDR_ARG1=16'h037F, ADDR_ARG2=16'h0388, ADDR_RES=16'h0390, ADDR_STAT=16'h03A0
//    - status bit positions STAT_BUSY=0, STAT_DONE=1, STAT_OVF=2
//  One natural sub-module: gpioemu_popcount (purely combinational, WIDTH in, CNT_W out), instantiated once on final acc.
//  Everything else (FSM, datapath registers, counter) stays in this file.
// TESTING
//  1. reset pulse, then A=2, B=8, start -> busy for 4 cycles, done=1, result=0x10, overflow=0, ones=1.
//  2. A=0x10, B=0x80, start -> busy for 8 cycles, result=0x800, overflow=0, ones=1.
//  3. A=0x80000, B=0x8007, start -> product 0x4_0038_0000, so result=0x00380000, overflow=1, ones=3.
//  4. A=0xFFFFFFFF, B=0 -> busy for exactly 1 cycle, result=0, overflow=0, ones=0.
//     Then A=0xFFFFFFFF, B=0xFFFFFFFF -> 32 RUN cycles, result=0x00000001, overflow=1, ones=1.
//  5. A=3, B=0x100 started; while busy, start with A=5, B=5 -> second start ignored, result=0x300.
//  6. A=7, B=0x8000 started; reset asserted on the 3rd RUN cycle -> next edge busy=done=result=overflow=ones=0,
//     state=IDLE. A fresh start afterwards with A=2, B=8 gives result=0x10.
//  All cases: the bench checks cycle-exact busy/done timing against msb_index(B)+1 and compares results
//  against a 64-bit reference product.

Source files
------------

// File: rtl/gpioemu_pkg.sv
// Shared constants for the gpioemu block family: FSM encoding, register map and status bits.
package gpioemu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  localparam logic [15:0] ADDR_ARG1 = 16'h037F;
  localparam logic [15:0] ADDR_ARG2 = 16'h0388;
  localparam logic [15:0] ADDR_RES  = 16'h0390;
  localparam logic [15:0] ADDR_STAT = 16'h03A0;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

endpackage

// File: rtl/gpioemu_mul_core_if.sv
// Request/response bundle between the gpioemu register file (master) and the multiplier core (slave).
interface gpioemu_mul_core_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             start;
  logic [WIDTH-1:0] arg_a;
  logic [WIDTH-1:0] arg_b;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] ones;

  modport master (
    output start, arg_a, arg_b,
    input  busy, done, overflow, result, ones
  );

  modport slave (
    input  start, arg_a, arg_b,
    output busy, done, overflow, result, ones
  );
endinterface

// File: rtl/gpioemu_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module gpioemu_popcount #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/gpioemu_mul_core.sv
// Iterative shift-and-add multiplier with early exit once the remaining multiplier bits are zero.
module gpioemu_mul_core
  import gpioemu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  gpioemu_mul_core_if.slave  bus
);

  state_e             state, state_nx;
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0]   mplier, result_q;
  logic [CNT_W-1:0]   cnt, ones_q, ones_nx;
  logic               ovf_q, last;

  // acc_nx includes this cycle's partial product so the exit edge captures the final value
  always_comb begin
    acc_nx = mplier[0] ? acc + mcand : acc;
    last   = ((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));
  end

  gpioemu_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
    .vec   (acc_nx[WIDTH-1:0]),
    .count (ones_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = RUN;
      RUN:        if (last)      state_nx = DONE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ones_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.arg_a};
            mplier <= bus.arg_b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            result_q <= acc_nx[WIDTH-1:0];
            ovf_q    <= |acc_nx[2*WIDTH-1:WIDTH];
            ones_q   <= ones_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.overflow = ovf_q;
  assign bus.result   = result_q;
  assign bus.ones     = ones_q;

endmodule
